lif_tdm_scheduler: RTL and testbench

//  Time-multiplexes one LIF membrane-update datapath across N_NEURONS virtual neurons.

---
 rtl/lif_pkg.sv | 14 +
 rtl/lif_tdm_scheduler_update.sv | 21 ++
 rtl/lif_tdm_scheduler.sv | 142 ++++++++++++++
 tb/tb_lif_tdm_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: shared FSM states, default widths and the saturating adder for the LIF scheduler.
package lif_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  localparam int LIF_W = 8;
  localparam int LIF_THRESH_RST = 230;
  // Saturates a+b at 2^w-1; operands are zero-extended, so w may be anything up to 16.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b, input int w);
    logic [16:0] s;
    logic [16:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (17'd1 << w) - 17'd1;
    return (s > m) ? m[15:0] : s[15:0];
  endfunction
endpackage

// File: rtl/lif_tdm_scheduler_update.sv
// lif_update: combinational LIF membrane update, U' = spike ? 0 : sat(I + 7/8 U), spike = U >= thresh.
module lif_update
  import lif_pkg::*;
#(
  parameter int W = LIF_W
) (
  input  logic [W-1:0] u,
  input  logic [W-1:0] i,
  input  logic [W-1:0] thresh,
  output logic [W-1:0] u_next,
  output logic         spike
);
  logic [W-1:0] leak;
  logic [W-1:0] sum;
  always_comb begin
    leak   = (u >> 1) + (u >> 2) + (u >> 3);
    sum    = W'(sat_add(16'(i), 16'(leak), W));
    spike  = u >= thresh;
    u_next = spike ? '0 : sum;
  end
endmodule

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: sweeps N virtual LIF neurons through one update datapath per step_start.
// Optional refractory counters are enabled by defining LIF_REFRACTORY_EN.
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int W          = LIF_W,
  parameter int THRESH_RST = LIF_THRESH_RST,
  parameter int REFRAC_T   = 2,
  localparam int IW = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cur_valid,
  output logic          cur_ready,
  input  logic [IW-1:0] cur_idx,
  input  logic [W-1:0]  cur_data,
  input  logic          step_start,
  output logic          busy,
  output logic          step_done,
  output logic          overrun,
  output logic          spike_valid,
  output logic [IW-1:0] spike_idx,
  input  logic          cfg_we,
  input  logic [W-1:0]  cfg_thresh,
  output logic [W-1:0]  threshold
);
  if (N_NEURONS < 2 || N_NEURONS > 16 || REFRAC_T < 1) begin : g_bad_param
    $error("lif_tdm_scheduler: unsupported parameters");
  end
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  u_q [N_NEURONS];
  logic [W-1:0]  u_d [N_NEURONS];
  logic [W-1:0]  i_q [N_NEURONS];
  logic [W-1:0]  i_d [N_NEURONS];
  logic [W-1:0]  u_lat_q, u_lat_d, i_lat_q, i_lat_d;
  logic [W-1:0]  thresh_q, thresh_d;
  logic          overrun_q, overrun_d, step_done_q, step_done_d;
  logic [W-1:0]  u_next, u_wr;
  logic          spike, spike_eff;
  lif_update #(.W(W)) u_update (
    .u      (u_lat_q),
    .i      (i_lat_q),
    .thresh (thresh_q),
    .u_next (u_next),
    .spike  (spike)
  );
`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_T + 1);
  logic [RW-1:0] ref_q [N_NEURONS];
  logic [RW-1:0] ref_d [N_NEURONS];
  logic          refr;
  always_comb begin
    refr      = ref_q[idx_q] != '0;
    spike_eff = spike && !refr;
    u_wr      = refr ? '0 : u_next;
    ref_d     = ref_q;
    if (state_q == WR)
      ref_d[idx_q] = refr ? ref_q[idx_q] - RW'(1) : (spike ? RW'(REFRAC_T) : ref_q[idx_q]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int k = 0; k < N_NEURONS; k++) ref_q[k] <= '0;
    else ref_q <= ref_d;
  end
`else
  always_comb begin
    spike_eff = spike;
    u_wr      = u_next;
  end
`endif
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    u_d         = u_q;
    i_d         = i_q;
    u_lat_d     = u_lat_q;
    i_lat_d     = i_lat_q;
    thresh_d    = thresh_q;
    overrun_d   = overrun_q;
    step_done_d = state_q == DONE;
    busy        = state_q != IDLE;
    cur_ready   = !(state_q == RD && cur_idx == idx_q);
    spike_valid = state_q == WR && spike_eff;
    spike_idx   = idx_q;
    // The stall above guarantees this write never targets the slot being cleared in RD.
    if (cur_valid && cur_ready) i_d[cur_idx] = W'(sat_add(16'(i_q[cur_idx]), 16'(cur_data), W));
    if (step_start && busy) overrun_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (step_start) begin
          state_d = RD;
          idx_d   = '0;
        end
        if (cfg_we) begin
          thresh_d  = cfg_thresh;
          overrun_d = 1'b0;
        end
      end
      RD: begin
        u_lat_d    = u_q[idx_q];
        i_lat_d    = i_q[idx_q];
        i_d[idx_q] = '0;
        state_d    = WR;
      end
      WR: begin
        u_d[idx_q] = u_wr;
        idx_d      = idx_q + IW'(1);
        state_d    = (idx_q == IW'(N_NEURONS - 1)) ? DONE : RD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      u_lat_q     <= '0;
      i_lat_q     <= '0;
      thresh_q    <= W'(THRESH_RST);
      overrun_q   <= 1'b0;
      step_done_q <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        u_q[k] <= '0;
        i_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      u_lat_q     <= u_lat_d;
      i_lat_q     <= i_lat_d;
      thresh_q    <= thresh_d;
      overrun_q   <= overrun_d;
      step_done_q <= step_done_d;
      u_q         <= u_d;
      i_q         <= i_d;
    end
  end
  assign step_done = step_done_q;
  assign overrun   = overrun_q;
  assign threshold = thresh_q;
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb_lif_tdm_scheduler: scoreboard bench; a reference model predicts each sweep's spikes and membranes.
module tb_lif_tdm_scheduler;
  localparam int N = 4;
  localparam int REFRAC_T = 2;
  logic       clk = 0, rst_n = 0, cur_valid = 0, step_start = 0, cfg_we = 0;
  logic [1:0] cur_idx = 0;
  logic [7:0] cur_data = 0, cfg_thresh = 0;
  logic       cur_ready, busy, step_done, overrun, spike_valid;
  logic [1:0] spike_idx;
  logic [7:0] threshold;
  int passed = 0, total = 0;
  typedef struct {int idx; int cyc;} spk_t;
  spk_t exp_q[$];
  int mu[N], mi[N], mref[N], mthr;

  lif_tdm_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cur_valid(cur_valid), .cur_ready(cur_ready),
    .cur_idx(cur_idx), .cur_data(cur_data), .step_start(step_start), .busy(busy),
    .step_done(step_done), .overrun(overrun), .spike_valid(spike_valid),
    .spike_idx(spike_idx), .cfg_we(cfg_we), .cfg_thresh(cfg_thresh), .threshold(threshold)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mu[k] = 0; mi[k] = 0; mref[k] = 0;
    end
    mthr = 230;
  endfunction

  function automatic void model_step();
    for (int k = 0; k < N; k++) begin
      int u, i, s;
      u = mu[k]; i = mi[k]; mi[k] = 0;
`ifdef LIF_REFRACTORY_EN
      if (mref[k] != 0) begin
        mu[k] = 0; mref[k]--;
        continue;
      end
`endif
      if (u >= mthr) begin
        exp_q.push_back(spk_t'{k, 2 * k + 2});
        mu[k] = 0; mref[k] = REFRAC_T;
      end else begin
        s = i + (u >> 1) + (u >> 2) + (u >> 3);
        mu[k] = s > 255 ? 255 : s;
      end
    end
  endfunction

  task automatic write_cur(input int k, input int d);
    @(posedge clk); #1 cur_valid = 1; cur_idx = 2'(k); cur_data = 8'(d);
    @(negedge clk);
    total++;
    if (cur_ready !== 1'b1) $display("FAIL write_ready idx=%0d got %b want 1", k, cur_ready);
    else passed++;
    @(posedge clk); #1 cur_valid = 0;
    mi[k] = (mi[k] + d > 255) ? 255 : mi[k] + d;
  endtask

  task automatic set_thresh(input int t);
    @(posedge clk); #1 cfg_we = 1; cfg_thresh = 8'(t);
    @(posedge clk); #1 cfg_we = 0;
    mthr = t;
  endtask

  // inject: 0 none, 1 collision write of d to neuron 1, 2 step_start and cfg_we while busy
  task automatic run_step(input int inject, input int d);
    int n;
    bit done;
    spk_t e;
    model_step();
    @(posedge clk); #1 step_start = 1;
    @(posedge clk); #1 step_start = 0;
    n = 0; done = 0;
    while (!done && n < 40) begin
      @(negedge clk); n++;
      if (spike_valid) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL spike_unexpected idx=%0d cyc=%0d want none", spike_idx, n);
        else begin
          e = exp_q.pop_front();
          if (spike_idx !== 2'(e.idx) || n != e.cyc)
            $display("FAIL spike idx=%0d cyc=%0d want idx=%0d cyc=%0d", spike_idx, n, e.idx, e.cyc);
          else passed++;
        end
      end
      if (n == 1) begin
        total++;
        if (busy !== 1'b1) $display("FAIL busy_in_sweep got %b want 1", busy); else passed++;
      end
      if (inject == 1 && n == 3) begin
        cur_valid = 1; cur_idx = 1; cur_data = 8'(d);
        #1 total++;
        if (cur_ready !== 1'b0) $display("FAIL collision_stall got %b want 0", cur_ready); else passed++;
      end
      if (inject == 1 && n == 4) begin
        total++;
        if (cur_ready !== 1'b1) $display("FAIL collision_release got %b want 1", cur_ready); else passed++;
      end
      if (inject == 1 && n == 5) cur_valid = 0;
      if (inject == 2 && n == 4) begin
        step_start = 1; cfg_we = 1; cfg_thresh = 7;
      end
      if (inject == 2 && n == 5) begin
        step_start = 0; cfg_we = 0;
      end
      if (step_done === 1'b1) done = 1;
    end
    total++;
    if (n - 1 != 2 * N + 1) $display("FAIL step_latency got %0d want %0d", n - 1, 2 * N + 1); else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL spike_missing got %0d left want 0", exp_q.size()); else passed++;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (step_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL step_done_pulse got done=%b busy=%b want 0 0", step_done, busy);
    else passed++;
    if (inject == 1) mi[1] = (mi[1] + d > 255) ? 255 : mi[1] + d;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, step_done, spike_valid, overrun} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {busy, step_done, spike_valid, overrun});
    else passed++;
    total++;
    if (threshold !== 8'd230) $display("FAIL reset_thresh got %0d want 230", threshold); else passed++;
    total++;
    if (cur_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cur_ready); else passed++;
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_idle_step();
    run_step(0, 0);
    for (int k = 0; k < N; k++) begin
      total++;
      if (dut.u_q[k] !== 8'd0) $display("FAIL idle_u%0d got %0d want 0", k, dut.u_q[k]); else passed++;
    end
  endtask

  task automatic test_accum();
    write_cur(2, 100);
    write_cur(2, 100);
    run_step(0, 0);
    total++;
    if (dut.u_q[2] !== 8'd200) $display("FAIL accum_u2 got %0d want 200", dut.u_q[2]); else passed++;
    write_cur(2, 100);
    run_step(0, 0);
    total++;
    if (dut.u_q[2] !== 8'd255) $display("FAIL sat_u2 got %0d want 255", dut.u_q[2]); else passed++;
    run_step(0, 0);
    total++;
    if (dut.u_q[2] !== 8'd0) $display("FAIL spike_u2 got %0d want 0", dut.u_q[2]); else passed++;
  endtask

  task automatic test_collision();
    run_step(1, 40);
    run_step(0, 0);
    total++;
    if (dut.u_q[1] !== 8'd40) $display("FAIL collision_u1 got %0d want 40", dut.u_q[1]); else passed++;
  endtask

  task automatic test_overrun();
    run_step(2, 0);
    total++;
    if (overrun !== 1'b1 || threshold !== 8'd230)
      $display("FAIL overrun_set got ovr=%b th=%0d want 1 230", overrun, threshold);
    else passed++;
    set_thresh(50);
    @(negedge clk);
    total++;
    if (overrun !== 1'b0 || threshold !== 8'd50)
      $display("FAIL cfg_idle got ovr=%b th=%0d want 0 50", overrun, threshold);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      for (int w = 0; w < 3; w++) write_cur(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 120)));
      run_step(0, 0);
      for (int k = 0; k < N; k++) begin
        total++;
        if (int'(dut.u_q[k]) != mu[k]) $display("FAIL b2b_u%0d got %0d want %0d", k, dut.u_q[k], mu[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_thresh_zero();
    set_thresh(0);
    run_step(0, 0);
    run_step(0, 0);
  endtask

  task automatic test_async_reset();
    write_cur(0, 200);
    write_cur(3, 90);
    @(posedge clk); #1 step_start = 1;
    @(posedge clk); #1 step_start = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1 model_reset();
    total++;
    if (busy !== 1'b0 || spike_valid !== 1'b0 || threshold !== 8'd230)
      $display("FAIL areset_ctrl got busy=%b sv=%b th=%0d want 0 0 230", busy, spike_valid, threshold);
    else passed++;
    for (int k = 0; k < N; k++) begin
      total++;
      if (dut.u_q[k] !== 8'd0 || dut.i_q[k] !== 8'd0)
        $display("FAIL areset_n%0d got u=%0d i=%0d want 0 0", k, dut.u_q[k], dut.i_q[k]);
      else passed++;
    end
    @(posedge clk); #1 rst_n = 1;
    run_step(0, 0);
  endtask

  initial begin
    test_reset();
    test_idle_step();
    test_accum();
    test_collision();
    test_overrun();
    test_back_to_back();
    test_thresh_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
